// File: rtl/tt_um_wade_divider_if.sv
// Pad-ring bus bundle for the Tiny Tapeout divider tile.
// The divider is the slave; the surrounding harness or bench is the master.
interface tt_um_wade_divider_if;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

endinterface

// File: rtl/tt_um_wade_divider.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// uio[3:0] are control inputs, uio[7:4] are status outputs.
module tt_um_wade_divider (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    tt_um_wade_divider_if.slave  bus
);

    localparam int unsigned DataW = 8;
    localparam int unsigned RemW  = DataW + 1;
    localparam int unsigned CntW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DataW-1:0]  a_q, a_d;
    logic [DataW-1:0]  b_q, b_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [DataW-1:0]  quo_q, quo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DataW-1:0]  res_q_q, res_q_d;
    logic [DataW-1:0]  res_r_q, res_r_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div0_q, div0_d;

    logic              ld_a_c;
    logic              ld_b_c;
    logic              start_c;
    logic              out_sel_c;
    logic [RemW-1:0]   shifted_c;
    logic [RemW:0]     trial_c;

    assign ld_a_c    = bus.uio_in[0];
    assign ld_b_c    = bus.uio_in[1];
    assign start_c   = bus.uio_in[2];
    assign out_sel_c = bus.uio_in[3];

    // Restoring trial subtraction; the extra top bit is the borrow/sign.
    assign shifted_c = {rem_q[DataW-1:0], quo_q[DataW-1]};
    assign trial_c   = {1'b0, shifted_c} - {2'b00, b_q};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q_q <= '0;
            res_r_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    // Next-state: operand loads and start when not running, one restoring step per clock in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;
        busy_d  = busy_q;
        done_d  = done_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE, DONE: begin
                if (ld_a_c) begin
                    a_d = bus.ui_in;
                end
                if (ld_b_c) begin
                    b_d = bus.ui_in;
                end
                // Start consumes the operands held before this edge.
                if (start_c) begin
                    if (b_q != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        div0_d  = 1'b0;
                        rem_d   = '0;
                        quo_d   = a_q;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        div0_d  = 1'b1;
                        res_q_d = '1;
                        res_r_d = a_q;
                    end
                end
            end

            RUN: begin
                if (!trial_c[RemW]) begin
                    rem_d = trial_c[RemW-1:0];
                    quo_d = {quo_q[DataW-2:0], 1'b1};
                end else begin
                    rem_d = shifted_c;
                    quo_d = {quo_q[DataW-2:0], 1'b0};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(7)) begin
                    res_q_d = quo_d;
                    res_r_d = rem_d[DataW-1:0];
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result mux is combinational over the held result registers.
    assign bus.uo_out  = out_sel_c ? res_r_q : res_q_q;
    assign bus.uio_out = {1'b0, div0_q, done_q, busy_q, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

    logic unused_c;
    assign unused_c = &{1'b0, ena, bus.uio_in[7:4], rem_q[RemW-1]};

endmodule

// File: tb/tb_tt_um_wade_divider.sv
// Self-checking bench for the sequential divider tile.
module tb_tt_um_wade_divider;

    logic clk;
    logic rst_n;
    logic ena;

    int checks;
    int errors;

    tt_um_wade_divider_if bus ();

    tt_um_wade_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: plain integer division, div-by-zero gives FF / A.
    function automatic void ref_div(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = 255;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic ld_a, input logic ld_b, input logic start, input logic sel);
        bus.uio_in = {4'b0000, sel, start, ld_b, ld_a};
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        bus.ui_in = a;
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.ui_in = b;
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Pulses start for one edge, then counts edges (acceptance edge = 1) until done, bounded.
    task automatic start_and_wait(output int cycles);
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        cycles = 1;
        while (bus.uio_out[5] !== 1'b1 && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_done_from(input int start_cnt, output int cycles);
        cycles = start_cnt;
        while (bus.uio_out[5] !== 1'b1 && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic read_result(output logic [7:0] q, output logic [7:0] r);
        bus.uio_in[3] = 1'b0;
        #1;
        q = bus.uo_out;
        bus.uio_in[3] = 1'b1;
        #1;
        r = bus.uo_out;
        bus.uio_in[3] = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] q, r;
        rst_n = 1'b0;
        bus.ui_in = 8'hA5;
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (bus.uio_oe !== 8'hF0) begin
            errors++;
            $display("FAIL reset_oe_during: got %h want f0", bus.uio_oe);
        end
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        read_result(q, r);
        checks++;
        if (q !== 8'h00 || r !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo: got q=%h r=%h want 00/00", q, r);
        end
        checks++;
        if (bus.uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_status: got %h want 00", bus.uio_out);
        end
        checks++;
        if (bus.uio_oe !== 8'hF0) begin
            errors++;
            $display("FAIL reset_oe: got %h want f0", bus.uio_oe);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q, r;
        int eq, er;
        int busy_bad;
        busy_bad = 0;
        load_ops(8'd200, 8'd7);
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.uio_out !== 8'h10) begin
            errors++;
            $display("FAIL basic_accept_status: got %h want 10", bus.uio_out);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.uio_out !== 8'h10 || bus.uio_oe !== 8'hF0) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL basic_busy_run: got %0d bad cycles want 0", busy_bad);
        end
        tick();
        checks++;
        if (bus.uio_out !== 8'h20) begin
            errors++;
            $display("FAIL basic_done_edge9: got %h want 20", bus.uio_out);
        end
        ref_div(200, 7, eq, er);
        read_result(q, r);
        checks++;
        if (q !== 8'(eq) || r !== 8'(er)) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d want q=%0d r=%0d", q, r, eq, er);
        end
    endtask

    task automatic test_corners();
        int ta [5] = '{255, 5, 0, 171, 1};
        int tb [5] = '{1, 9, 3, 171, 255};
        logic [7:0] q, r;
        int eq, er, cyc;
        for (int i = 0; i < 5; i++) begin
            load_ops(8'(ta[i]), 8'(tb[i]));
            start_and_wait(cyc);
            ref_div(ta[i], tb[i], eq, er);
            read_result(q, r);
            checks++;
            if (cyc != 9 || q !== 8'(eq) || r !== 8'(er) || bus.uio_out[6] !== 1'b0) begin
                errors++;
                $display("FAIL corner_%0d_%0d: got q=%0d r=%0d cyc=%0d div0=%b want q=%0d r=%0d cyc=9 div0=0",
                         ta[i], tb[i], q, r, cyc, bus.uio_out[6], eq, er);
            end
        end
    endtask

    task automatic test_div0();
        logic [7:0] q, r;
        int cyc;
        load_ops(8'd100, 8'd0);
        start_and_wait(cyc);
        read_result(q, r);
        checks++;
        if (cyc != 1 || bus.uio_out !== 8'h60 || q !== 8'hFF || r !== 8'd100) begin
            errors++;
            $display("FAIL div0_result: got cyc=%0d st=%h q=%h r=%0d want cyc=1 st=60 q=ff r=100",
                     cyc, bus.uio_out, q, r);
        end
        bus.ui_in = 8'd10;
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        start_and_wait(cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || bus.uio_out !== 8'h20 || q !== 8'd10 || r !== 8'd0) begin
            errors++;
            $display("FAIL div0_recover: got cyc=%0d st=%h q=%0d r=%0d want cyc=9 st=20 q=10 r=0",
                     cyc, bus.uio_out, q, r);
        end
    endtask

    task automatic test_run_ignore();
        logic [7:0] q, r;
        int cyc;
        load_ops(8'd200, 8'd7);
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.ui_in = 8'd9;
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        bus.ui_in = 8'd2;
        set_ctrl(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        wait_done_from(4, cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || q !== 8'd28 || r !== 8'd4) begin
            errors++;
            $display("FAIL run_ignore: got cyc=%0d q=%0d r=%0d want cyc=9 q=28 r=4", cyc, q, r);
        end
        start_and_wait(cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || q !== 8'd28 || r !== 8'd4) begin
            errors++;
            $display("FAIL run_ignore_regs: got cyc=%0d q=%0d r=%0d want cyc=9 q=28 r=4", cyc, q, r);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] q, r;
        int cyc;
        load_ops(8'd200, 8'd7);
        bus.ui_in = 8'd50;
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        wait_done_from(1, cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || q !== 8'd28 || r !== 8'd4) begin
            errors++;
            $display("FAIL same_cycle_old: got cyc=%0d q=%0d r=%0d want cyc=9 q=28 r=4", cyc, q, r);
        end
        start_and_wait(cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || q !== 8'd7 || r !== 8'd1) begin
            errors++;
            $display("FAIL same_cycle_new: got cyc=%0d q=%0d r=%0d want cyc=9 q=7 r=1", cyc, q, r);
        end
    endtask

    task automatic test_held_start();
        logic [7:0] q, r;
        int cyc;
        load_ops(8'd13, 8'd5);
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        wait_done_from(1, cyc);
        checks++;
        if (cyc != 9) begin
            errors++;
            $display("FAIL held_start_latency: got %0d want 9", cyc);
        end
        tick();
        checks++;
        if (bus.uio_out !== 8'h10) begin
            errors++;
            $display("FAIL held_start_reaccept: got %h want 10", bus.uio_out);
        end
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        wait_done_from(1, cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || q !== 8'd2 || r !== 8'd3) begin
            errors++;
            $display("FAIL held_start_result: got cyc=%0d q=%0d r=%0d want cyc=9 q=2 r=3", cyc, q, r);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] q, r;
        int cyc;
        load_ops(8'd200, 8'd7);
        set_ctrl(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        read_result(q, r);
        checks++;
        if (bus.uio_out !== 8'h00 || q !== 8'd0 || r !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got st=%h q=%0d r=%0d want st=00 q=0 r=0", bus.uio_out, q, r);
        end
        // Operand registers were cleared too: start without reloading is a div-by-zero of 0.
        start_and_wait(cyc);
        read_result(q, r);
        checks++;
        if (cyc != 1 || bus.uio_out !== 8'h60 || q !== 8'hFF || r !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_operands: got cyc=%0d st=%h q=%h r=%0d want cyc=1 st=60 q=ff r=0",
                     cyc, bus.uio_out, q, r);
        end
        load_ops(8'd81, 8'd9);
        start_and_wait(cyc);
        read_result(q, r);
        checks++;
        if (cyc != 9 || q !== 8'd9 || r !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_fresh: got cyc=%0d q=%0d r=%0d want cyc=9 q=9 r=0", cyc, q, r);
        end
    endtask

    task automatic test_random();
        logic [7:0] q, r;
        int a, b, eq, er, cyc;
        for (int n = 0; n < 1500; n++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            load_ops(8'(a), 8'(b));
            start_and_wait(cyc);
            ref_div(a, b, eq, er);
            read_result(q, r);
            checks++;
            if (cyc != 9 || q !== 8'(eq) || r !== 8'(er) ||
                (int'(q) * b + int'(r)) != a || int'(r) >= b || bus.uio_out !== 8'h20) begin
                errors++;
                $display("FAIL random_%0d_%0d: got q=%0d r=%0d cyc=%0d st=%h want q=%0d r=%0d cyc=9 st=20",
                         a, b, q, r, cyc, bus.uio_out, eq, er);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ena       = 1'b1;
        rst_n     = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        test_reset();
        test_basic();
        test_corners();
        test_div0();
        test_run_ignore();
        test_same_cycle();
        test_held_start();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
